udp_tx: RTL



---
 rtl/udp_tx.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/udp_tx.sv
// UDP transmit encapsulator: prepends the 8-byte UDP header (MSB first) to an
// AXI-Stream payload. The output is a registered stage with a one-entry skid
// buffer, so s_tx_axis_trdy never depends combinationally on m_tx_axis_trdy.
// Build option: define UDP_TX_ZERO_CSUM_EN to force the checksum bytes to 0x0000.
module udp_tx #(
   parameter int AXI_DATA_WIDTH = 8
) (
   input  logic                      i_clk,
   input  logic                      i_reset_n,
   input  logic                      s_udp_hdr_tvalid,
   output logic                      s_udp_hdr_trdy,
   input  logic [15:0]               s_udp_src_port,
   input  logic [15:0]               s_udp_dst_port,
   input  logic [15:0]               s_udp_length,
   input  logic [15:0]               s_udp_hdr_checksum,
   input  logic [AXI_DATA_WIDTH-1:0] s_tx_axis_tdata,
   input  logic                      s_tx_axis_tvalid,
   input  logic                      s_tx_axis_tlast,
   output logic                      s_tx_axis_trdy,
   output logic [AXI_DATA_WIDTH-1:0] m_tx_axis_tdata,
   output logic                      m_tx_axis_tvalid,
   output logic                      m_tx_axis_tlast,
   input  logic                      m_tx_axis_trdy
);

   typedef enum logic [1:0] {IDLE, HDR, PAYLOAD} state_t;

   state_t                    state, state_n;
   logic [63:0]               hdr, hdr_n;
   logic [2:0]                cnt, cnt_n;
   logic [AXI_DATA_WIDTH-1:0] out_data, out_data_n, skid_data, skid_data_n;
   logic                      out_valid, out_valid_n, out_last, out_last_n;
   logic                      skid_valid, skid_valid_n, skid_last, skid_last_n;
   logic                      last_seen, last_seen_n;
   logic                      in_trdy, in_trdy_n, hdr_trdy, hdr_trdy_n;
   logic                      m_hs, in_hs, hdr_hs, out_free, pass_en;
   logic [15:0]               csum_in;

`ifdef UDP_TX_ZERO_CSUM_EN
   logic                      unused_csum;
   assign unused_csum = ^s_udp_hdr_checksum;
   assign csum_in     = 16'h0000;
`else
   assign csum_in     = s_udp_hdr_checksum;
`endif

   // Header byte i of the latched header, byte 0 being src[15:8].
   function automatic logic [7:0] hdr_byte(input logic [63:0] h, input logic [2:0] i);
      logic [63:0] sh;
      sh = h << {i, 3'b000};
      return sh[63:56];
   endfunction

   assign m_hs     = out_valid & m_tx_axis_trdy;
   assign in_hs    = s_tx_axis_tvalid & in_trdy;
   assign hdr_hs   = s_udp_hdr_tvalid & hdr_trdy;
   assign out_free = ~out_valid | m_tx_axis_trdy;
   // Payload path is live while header byte 7 sits in the output register and throughout PAYLOAD.
   assign pass_en  = ((state == HDR) && (cnt == 3'd7)) || (state == PAYLOAD);

   assign s_udp_hdr_trdy   = hdr_trdy;
   assign s_tx_axis_trdy   = in_trdy;
   assign m_tx_axis_tdata  = out_data;
   assign m_tx_axis_tvalid = out_valid;
   assign m_tx_axis_tlast  = out_last;

   // State and datapath registers, synchronous active-low reset.
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         state      <= IDLE;
         hdr        <= '0;
         cnt        <= '0;
         out_data   <= '0;
         out_valid  <= 1'b0;
         out_last   <= 1'b0;
         skid_data  <= '0;
         skid_valid <= 1'b0;
         skid_last  <= 1'b0;
         last_seen  <= 1'b0;
         in_trdy    <= 1'b0;
         hdr_trdy   <= 1'b0;
      end else begin
         state      <= state_n;
         hdr        <= hdr_n;
         cnt        <= cnt_n;
         out_data   <= out_data_n;
         out_valid  <= out_valid_n;
         out_last   <= out_last_n;
         skid_data  <= skid_data_n;
         skid_valid <= skid_valid_n;
         skid_last  <= skid_last_n;
         last_seen  <= last_seen_n;
         in_trdy    <= in_trdy_n;
         hdr_trdy   <= hdr_trdy_n;
      end
   end

   // Next-state, header sequencing, output stage / skid buffer and ready generation.
   always_comb begin
      state_n      = state;
      hdr_n        = hdr;
      cnt_n        = cnt;
      out_data_n   = out_data;
      out_valid_n  = out_valid;
      out_last_n   = out_last;
      skid_data_n  = skid_data;
      skid_valid_n = skid_valid;
      skid_last_n  = skid_last;
      last_seen_n  = last_seen;

      case (state)
         IDLE: begin
            if (hdr_hs) begin
               hdr_n       = {s_udp_src_port, s_udp_dst_port, s_udp_length, csum_in};
               cnt_n       = 3'd0;
               out_data_n  = s_udp_src_port[15:8];
               out_valid_n = 1'b1;
               out_last_n  = 1'b0;
               last_seen_n = 1'b0;
               state_n     = HDR;
            end
         end
         HDR: begin
            if (m_hs) begin
               if (cnt != 3'd7) begin
                  cnt_n      = cnt + 3'd1;
                  out_data_n = hdr_byte(hdr, cnt + 3'd1);
               end else begin
                  cnt_n   = 3'd0;
                  state_n = PAYLOAD;
               end
            end
         end
         PAYLOAD: begin
            if (m_hs && out_last) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase

      // Skid buffer: only accept upstream when the skid is empty (in_trdy), so at
      // most one byte is ever parked while the output register is stalled.
      if (pass_en) begin
         if (out_free) begin
            if (skid_valid) begin
               out_data_n   = skid_data;
               out_last_n   = skid_last;
               out_valid_n  = 1'b1;
               skid_valid_n = 1'b0;
            end else if (in_hs) begin
               out_data_n  = s_tx_axis_tdata;
               out_last_n  = s_tx_axis_tlast;
               out_valid_n = 1'b1;
            end else begin
               out_valid_n = 1'b0;
               out_last_n  = 1'b0;
            end
         end else if (in_hs) begin
            skid_data_n  = s_tx_axis_tdata;
            skid_last_n  = s_tx_axis_tlast;
            skid_valid_n = 1'b1;
         end
         if (in_hs && s_tx_axis_tlast) last_seen_n = 1'b1;
      end

      in_trdy_n  = (((state_n == HDR) && (cnt_n == 3'd7)) || (state_n == PAYLOAD))
                   && !skid_valid_n && !last_seen_n;
      hdr_trdy_n = (state_n == IDLE);
   end

endmodule
